// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: arbiter state encoding, fixed requester indices and the tape/FDD round-robin helper.
package ram_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
   localparam int REQ_DMA  = 0;
   localparam int REQ_TAPE = 1;
   localparam int REQ_FDD  = 2;
   localparam int REQ_CPU  = 3;
   // Returns {fdd, tape} one-hot; rr = 1 favours FDD when both ask.
   function automatic logic [1:0] rr_pick(input logic t, input logic f, input logic rr);
      return (t && f) ? (rr ? 2'b10 : 2'b01) : {f, t};
   endfunction
endpackage

// File: rtl/ram_arb_select.sv
// ram_arb_select: combinational one-hot winner; DMA first, then starved tape/FDD, then CPU, then tape/FDD round-robin.
module ram_arb_select
   import ram_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0] i_req,
   input  logic            i_rr,
   input  logic [1:0]      i_starve,
   output logic [NREQ-1:0] o_sel
);
   logic [1:0] w_norm, w_hung;
   assign w_norm = rr_pick(i_req[REQ_TAPE], i_req[REQ_FDD], i_rr);
   assign w_hung = rr_pick(i_req[REQ_TAPE] & i_starve[0], i_req[REQ_FDD] & i_starve[1], i_rr);
   always_comb begin
      o_sel = '0;
      if (i_req[REQ_DMA]) o_sel[REQ_DMA] = 1'b1;
      else if (|w_hung) {o_sel[REQ_FDD], o_sel[REQ_TAPE]} = w_hung;
      else if (i_req[REQ_CPU]) o_sel[REQ_CPU] = 1'b1;
      else {o_sel[REQ_FDD], o_sel[REQ_TAPE]} = w_norm;
   end
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: request/grant/ack sharing of the single SDRAM byte port, one operation at a time.
// Define ARB_STARVE_GUARD_EN to let a starved tape/FDD requester overtake the CPU.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int AW         = 25,
   parameter int NREQ       = 4,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*8-1:0] req_din,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   ack,
   output logic [7:0]        rdata,
   output logic [AW-1:0]     mem_addr,
   output logic [7:0]        mem_din,
   output logic              mem_we,
   output logic              mem_rd,
   input  logic [7:0]        mem_dout,
   input  logic              mem_ready,
   output logic              busy
);
   arb_state_t      r_state, w_next;
   logic [NREQ-1:0] r_grant, w_sel;
   logic [AW-1:0]   r_addr, w_addr;
   logic [7:0]      r_din, w_din, r_rdata;
   logic            r_we, w_we, r_wcnt, r_rr, w_pick, w_done;
   logic [1:0]      w_starve;

   if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve
      $error("STARVE_MAX must fit the 3-bit starvation counters");
   end

   assign w_pick = (r_state == IDLE) && (|req) && mem_ready;
   // Completion needs two WAIT cycles even if the sram never drops ready.
   assign w_done = (r_state == WAIT) && r_wcnt && mem_ready;

   ram_arb_select #(.NREQ(NREQ)) u_sel (
      .i_req   (req),
      .i_rr    (r_rr),
      .i_starve(w_starve),
      .o_sel   (w_sel)
   );

   always_comb begin
      w_addr = '0;
      w_din  = '0;
      w_we   = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         w_addr |= w_sel[i] ? req_addr[i*AW +: AW] : '0;
         w_din  |= w_sel[i] ? req_din[i*8 +: 8] : '0;
         w_we   |= w_sel[i] & req_we[i];
      end
   end

   always_ff @(posedge clk_sys or posedge reset)
      if (reset) r_state <= IDLE;
      else r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_pick ? ISSUE : IDLE;
         ISSUE:   w_next = WAIT;
         WAIT:    w_next = w_done ? DONE : WAIT;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset)
      if (reset) begin
         r_grant <= '0;
         r_addr  <= '0;
         r_din   <= '0;
         r_we    <= 1'b0;
         r_wcnt  <= 1'b0;
         r_rr    <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_wcnt <= r_state == WAIT;
         if (w_done && !r_we) r_rdata <= mem_dout;
         if (w_pick) begin
            r_grant <= w_sel;
            r_addr  <= w_addr;
            r_din   <= w_din;
            r_we    <= w_we;
            r_rr    <= w_sel[REQ_TAPE] | (r_rr & ~w_sel[REQ_FDD]);
         end else if (r_state == DONE) r_grant <= '0;
      end

`ifdef ARB_STARVE_GUARD_EN
   for (genvar g = 0; g < 2; g++) begin : g_starve
      logic [2:0] r_cnt;
      always_ff @(posedge clk_sys or posedge reset)
         if (reset) r_cnt <= '0;
         else if (w_pick)
            r_cnt <= w_sel[REQ_TAPE+g] ? 3'd0 :
                     (req[REQ_TAPE+g] && !w_sel[REQ_DMA] && r_cnt != 3'd7) ? r_cnt + 3'd1 : r_cnt;
      assign w_starve[g] = r_cnt >= 3'(STARVE_MAX);
   end
`else
   assign w_starve = 2'b00;
`endif

   always_comb begin
      grant    = r_grant;
      ack      = (r_state == DONE) ? r_grant : '0;
      rdata    = r_rdata;
      mem_addr = r_addr;
      mem_din  = r_din;
      mem_we   = (r_state == ISSUE) & r_we;
      mem_rd   = (r_state == ISSUE) & ~r_we;
      busy     = r_state != IDLE;
   end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vectors against a small sram model with hand-computed expectations.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;
   localparam int AW = 25;
   localparam int NREQ = 4;

   logic              clk_sys = 1'b0;
   logic              reset = 1'b1;
   logic [NREQ-1:0]   req = '0, req_we = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*8-1:0] req_din = '0;
   logic [NREQ-1:0]   grant, ack;
   logic [7:0]        rdata, mem_din, mem_dout;
   logic [AW-1:0]     mem_addr;
   logic              mem_we, mem_rd, mem_ready, busy;

   int n_cmp = 0, n_err = 0;
   int lowlen = 0;
   logic [7:0] rd_val = '0, m_data = '0;
   int m_cnt = 0, n_rd = 0, n_wr = 0, n_ack = 0;
   logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
   logic [7:0] last_wr_din = '0;

   always #5 clk_sys = ~clk_sys;

   ram_port_arbiter dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .req      (req),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_din  (req_din),
      .grant    (grant),
      .ack      (ack),
      .rdata    (rdata),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .mem_we   (mem_we),
      .mem_rd   (mem_rd),
      .mem_dout (mem_dout),
      .mem_ready(mem_ready),
      .busy     (busy)
   );

   // sram model: ready drops for lowlen cycles after each rd/we pulse
   always @(posedge clk_sys) begin
      if (mem_rd || mem_we) m_cnt <= lowlen;
      else if (m_cnt != 0) m_cnt <= m_cnt - 1;
      if (mem_rd) begin
         m_data       <= rd_val;
         n_rd         <= n_rd + 1;
         last_rd_addr <= mem_addr;
      end
      if (mem_we) begin
         n_wr         <= n_wr + 1;
         last_wr_addr <= mem_addr;
         last_wr_din  <= mem_din;
      end
      if (|ack) n_ack <= n_ack + 1;
   end
   assign mem_ready = (m_cnt == 0);
   assign mem_dout  = mem_ready ? m_data : 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
      req[i] = 1'b1;
      req_we[i] = we;
      req_addr[i*AW +: AW] = a;
      req_din[i*8 +: 8] = d;
   endtask

   task automatic wait_ack(input int budget, output int lat);
      lat = 0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk_sys);
         if (|ack) begin
            lat = i;
            return;
         end
      end
      chk("ack_timeout", 32'(|ack), 1);
   endtask

   task automatic wait_rd(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_sys);
         if (mem_rd) return;
      end
      chk("rd_timeout", 32'(mem_rd), 1);
   endtask

   task automatic do_reset();
      req = '0;
      reset = 1'b1;
      @(negedge clk_sys);
      reset = 1'b0;
      @(negedge clk_sys);
   endtask

   initial begin
      int lat, r0, w0, a0;
      logic [NREQ-1:0] exp;
      repeat (2) @(negedge clk_sys);
      chk("rst_grant", grant, 0);
      chk("rst_ack", ack, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_ctl", {mem_din, mem_we, mem_rd}, 0);
      reset = 1'b0;
      @(negedge clk_sys);

      // single CPU read, ready low for 3 cycles
      lowlen = 3; rd_val = 8'hA5; r0 = n_rd; w0 = n_wr; a0 = n_ack;
      set_req(REQ_CPU, 1'b0, 25'h051234, 8'h00);
      wait_ack(20, lat);
      chk("t1_lat", lat, 6);
      chk("t1_ack", ack, 4'b1000);
      chk("t1_grant", grant, 4'b1000);
      chk("t1_rdata", rdata, 8'hA5);
      chk("t1_rd_addr", last_rd_addr, 25'h051234);
      req = '0;
      repeat (3) @(negedge clk_sys);
      chk("t1_rd_pulses", n_rd - r0, 1);
      chk("t1_we_pulses", n_wr - w0, 0);
      chk("t1_acks", n_ack - a0, 1);
      chk("t1_idle", {grant, busy}, 0);

      // DMA write beats a simultaneous CPU read
      lowlen = 0; rd_val = 8'h77; r0 = n_rd; w0 = n_wr;
      set_req(REQ_DMA, 1'b1, 25'h181FFF, 8'h3C);
      set_req(REQ_CPU, 1'b0, 25'h000010, 8'h00);
      wait_ack(20, lat);
      chk("t2_dma_lat", lat, 4);
      chk("t2_dma_ack", ack, 4'b0001);
      chk("t2_dma_grant", grant, 4'b0001);
      chk("t2_wr_addr", last_wr_addr, 25'h181FFF);
      chk("t2_wr_din", last_wr_din, 8'h3C);
      chk("t2_rdata_kept", rdata, 8'hA5);
      req[REQ_DMA] = 1'b0;
      wait_ack(20, lat);
      chk("t2_cpu_lat", lat, 5);
      chk("t2_cpu_ack", ack, 4'b1000);
      chk("t2_cpu_rdata", rdata, 8'h77);
      req = '0;
      repeat (2) @(negedge clk_sys);
      chk("t2_we_pulses", n_wr - w0, 1);
      chk("t2_rd_pulses", n_rd - r0, 1);

      // tape and FDD held: alternate starting with tape
      do_reset();
      set_req(REQ_TAPE, 1'b0, 25'h000100, 8'h00);
      set_req(REQ_FDD, 1'b0, 25'h000200, 8'h00);
      for (int i = 0; i < 4; i++) begin
         wait_ack(20, lat);
         chk($sformatf("t3_ack%0d", i), ack, (i % 2 == 0) ? 4'b0010 : 4'b0100);
      end
      req = '0;

      // CPU held against tape
      do_reset();
      set_req(REQ_TAPE, 1'b0, 25'h000100, 8'h00);
      set_req(REQ_CPU, 1'b0, 25'h000300, 8'h00);
      for (int i = 0; i < 6; i++) begin
`ifdef ARB_STARVE_GUARD_EN
         exp = (i == 4) ? 4'b0010 : 4'b1000;
`else
         exp = 4'b1000;
`endif
         wait_ack(20, lat);
         chk($sformatf("t4_ack%0d", i), ack, exp);
      end
      req = '0;

      // reset asserted in WAIT abandons the operation
      do_reset();
      lowlen = 5; rd_val = 8'h5A; a0 = n_ack;
      set_req(REQ_CPU, 1'b0, 25'h1ABCDE, 8'h00);
      wait_rd(10);
      @(negedge clk_sys);
      chk("t5_in_wait", busy, 1);
      reset = 1'b1;
      #1;
      chk("t5_rst_grant", grant, 0);
      chk("t5_rst_ack", ack, 0);
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_mem", {mem_addr, mem_we, mem_rd}, 0);
      chk("t5_rst_rdata", rdata, 0);
      @(negedge clk_sys);
      reset = 1'b0;
      wait_ack(40, lat);
      chk("t5_ack", ack, 4'b1000);
      chk("t5_rdata", rdata, 8'h5A);
      req = '0;
      repeat (2) @(negedge clk_sys);
      chk("t5_acks", n_ack - a0, 1);

      // FDD drops req during WAIT; address change ignored
      lowlen = 2; r0 = n_rd; a0 = n_ack;
      set_req(REQ_FDD, 1'b0, 25'h0ABCDE, 8'h00);
      wait_rd(20);
      @(negedge clk_sys);
      req[REQ_FDD] = 1'b0;
      req_addr[REQ_FDD*AW +: AW] = 25'h1FFFFFF;
      wait_ack(20, lat);
      chk("t6_ack", ack, 4'b0100);
      chk("t6_mem_addr", mem_addr, 25'h0ABCDE);
      repeat (4) @(negedge clk_sys);
      chk("t6_idle", {grant, busy}, 0);
      chk("t6_rd_pulses", n_rd - r0, 1);
      chk("t6_acks", n_ack - a0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Sequences and shares the single SDRAM byte port (sram controller: addr/din/we/rd/dout/ready) among four requesters: ioctl DMA, tape buffer reader, FDD buffer reader and the CPU.
- Replaces the priority mux in the top level with explicit request/grant/ack handshakes, one outstanding memory operation at a time.
- Sits between requesters and the sram instance, all in the clk_sys domain.

Parameters:
- AW, 25, address width of the RAM port and of each requester address.
- NREQ, 4, number of requesters; fixed indices: 0 = DMA, 1 = tape, 2 = FDD, 3 = CPU.
- STARVE_MAX, 4, grants a waiting low-priority requester tolerates before forced service (used only with the optional feature).

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level; held until the matching ack.
- req_we  in  NREQ  1 = write, 0 = read, per requester.
- req_addr  in  NREQ*AW  packed addresses; requester i occupies [i*AW +: AW].
- req_din  in  NREQ*8  packed write data.
- grant  out  NREQ  one-hot; set for the whole operation of the selected requester.
- ack  out  NREQ  one-cycle pulse; operation complete.
- rdata  out  8  read data, valid in the ack cycle and held until the next ack.
- mem_addr  out  AW  to sram addr.
- mem_din  out  8  to sram din.
- mem_we  out  1  to sram we; one-cycle pulse.
- mem_rd  out  1  to sram rd; one-cycle pulse.
- mem_dout  in  8  from sram dout.
- mem_ready  in  1  sram idle/ready.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer selects tape; starvation counters 0.
- Reset mid-operation immediately returns the block to IDLE. The in-flight sram operation is abandoned and no ack is issued.
- State machine:
  - IDLE: when any req bit is set and mem_ready = 1, select a winner, latch its addr/din/we into mem_* registers, set grant, go to ISSUE.
  - ISSUE: assert mem_rd or mem_we for exactly one cycle, go to WAIT.
  - WAIT: stay until mem_ready = 1, no earlier than 2 cycles after ISSUE, then go to DONE. If mem_ready is never seen low, completion is still taken at 2 cycles.
  - DONE: capture mem_dout into rdata on reads (rdata is unchanged on writes), pulse ack for the winner, clear grant, go to IDLE.
- Minimum latency from req sampled in IDLE to ack: 4 cycles.
- Back-to-back operations: the next arbitration happens in the IDLE cycle after DONE. A requester must drop req in the cycle after ack, otherwise it is re-served.
- Arbitration priority:
  - DMA (0) is absolute.
  - Otherwise CPU (3) beats tape/FDD.
  - Tape (1) vs FDD (2) is round-robin; the pointer flips to the other after either of them is served.
- req dropped while granted: the operation still completes and ack still pulses; the requester ignores it. There is no cancel.
- addr/din/we are sampled only in IDLE at selection; later changes have no effect on the current operation.
- Simultaneous req from all four: DMA served. Then, if the others are still held, CPU; then tape or FDD per the pointer.
- Address width is passed through unmodified; no arithmetic on addresses.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - Each of tape/FDD has a 3-bit counter, incremented whenever it is requesting and another non-DMA requester is granted, and cleared when it is served.
  - When a counter reaches STARVE_MAX, that requester beats the CPU at the next arbitration. DMA still wins.
- Undefined: no counters; CPU always beats tape/FDD.

Decomposition:
- Package ram_arb_pkg: state enum (IDLE, ISSUE, WAIT, DONE) and requester index constants (REQ_DMA, REQ_TAPE, REQ_FDD, REQ_CPU).
- One sub-module, ram_arb_select: combinational winner selection from req, the round-robin pointer and the starvation flags, producing a one-hot output.

Test Plan:
- Single CPU read, addr 0x05_1234, mem_ready low 3 cycles after issue, mem_dout = 0xA5 -> exactly one mem_rd pulse with mem_addr = 0x05_1234; ack[3] pulses once; rdata = 0xA5.
- DMA write (addr 0x18_1FFF, din 0x3C) and CPU read requested in the same cycle -> grant[0] first, one mem_we pulse with din 0x3C; CPU granted only after ack[0].
- Tape and FDD both held continuously with CPU idle -> grants alternate 1, 2, 1, 2; first grant is tape after reset.
- CPU held continuously with tape held -> without the macro, tape is never granted. With ARB_STARVE_GUARD_EN and STARVE_MAX = 4, tape is granted after the 4th CPU ack.
- reset asserted in WAIT -> next cycle all outputs 0, busy = 0, no ack. After release, a pending request restarts from IDLE.
- req[2] dropped during WAIT -> ack[2] still pulses once; the next IDLE selects no requester if all req bits are 0.
